au_cmd_driver: RTL and testbench

- Command front-end and result collector for the packed arithmetic unit interface (au_ip out, au_o in).
- Accepts operation commands on a valid/ready stream and drives a registered au_ip bundle to an external combinational arithmetic unit.
- Captures the au_o result one cycle later, attaches status flags, and returns results through a 2-entry response buffer.
- Sits between the control/bus logic and the arith unit instance.

---
 rtl/au_cmd_driver.sv | 164 ++++++++++++++++
 tb/tb_au_cmd_driver.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_cmd_driver.sv
// Command front-end for the packed arithmetic unit: registers each command onto au_ip_o,
// captures au_o_i one cycle later with status flags, and returns results through a 2-entry FIFO.
module au_cmd_driver #(
    parameter int W     = 16,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_signed,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [2*W+2:0]   au_ip_o,
    input  logic [W-1:0]     au_o_i,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dbz,
    output logic             rsp_ovf,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q, state_d;
    logic [2*W+2:0]   au_ip_q, au_ip_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic [W-1:0]     buf_data_q [2];
    logic [TAG_W-1:0] buf_tag_q  [2];
    logic [1:0]       buf_dbz_q, buf_ovf_q;
    logic             head_q, head_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    logic             accept, push, pop, wr_idx;
    logic [W-1:0]     op_a, op_b;
    logic [1:0]       op_code;
    logic             op_signed;
    logic [W:0]       sum_w, diff_w;
    logic [W-1:0]     res_data;
    logic             res_dbz, res_ovf;

    assign {op_a, op_b, op_code, op_signed} = au_ip_q;
    assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_w = {1'b0, op_a} - {1'b0, op_b};

    // Flags come from the latched operands; au_o_i only supplies the data word.
    always_comb begin
        res_data = au_o_i;
        res_dbz  = 1'b0;
        res_ovf  = 1'b0;
        case (op_code)
            OP_ADD: res_ovf = op_signed ? ((op_a[W-1] == op_b[W-1]) && (sum_w[W-1] != op_a[W-1]))
                                        : sum_w[W];
            OP_SUB: res_ovf = op_signed ? ((op_a[W-1] != op_b[W-1]) && (diff_w[W-1] != op_a[W-1]))
                                        : diff_w[W];
            OP_MUL: res_ovf = 1'b0;
            OP_DIV: begin
                if (op_b == '0) begin
                    res_dbz  = 1'b1;
                    res_data = op_signed ? '0 : '1;
                end else begin
                    res_ovf = op_signed && (op_a == MOST_NEG) && (op_b == '1);
                end
            end
            default: res_ovf = 1'b0;
        endcase
    end

    // Accepting only with a free slot means the EXEC write can never be refused.
    always_comb begin
        state_d   = state_q;
        au_ip_d   = au_ip_q;
        tag_d     = tag_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !rst && (count_q < 2'd2);
                accept    = cmd_valid && cmd_ready;
                if (accept) begin
                    au_ip_d = {cmd_a, cmd_b, cmd_op, cmd_signed};
                    tag_d   = cmd_tag;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (count_q != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign wr_idx    = head_q ^ (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d = pop ? ~head_q : head_q;
        ops_d  = pop ? ops_q + CNT_W'(1) : ops_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            au_ip_q <= '0;
            tag_q   <= '0;
            head_q  <= 1'b0;
            count_q <= 2'd0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            au_ip_q <= au_ip_d;
            tag_q   <= tag_d;
            head_q  <= head_d;
            count_q <= count_d;
            ops_q   <= ops_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_tag_q[0]  <= '0;
            buf_tag_q[1]  <= '0;
            buf_dbz_q     <= '0;
            buf_ovf_q     <= '0;
        end else if (push) begin
            buf_data_q[wr_idx] <= res_data;
            buf_tag_q[wr_idx]  <= tag_q;
            buf_dbz_q[wr_idx]  <= res_dbz;
            buf_ovf_q[wr_idx]  <= res_ovf;
        end
    end

    assign au_ip_o  = au_ip_q;
    assign rsp_data = buf_data_q[head_q];
    assign rsp_tag  = buf_tag_q[head_q];
    assign rsp_dbz  = buf_dbz_q[head_q];
    assign rsp_ovf  = buf_ovf_q[head_q];
    assign ops_done = ops_q;

endmodule

// File: tb/tb_au_cmd_driver.sv
// Bench for au_cmd_driver: directed vector table, hand-built backpressure/reset sequences,
// and randomized traffic checked against an arithmetic reference model and a response queue.
module tb_au_cmd_driver;

    localparam int W     = 16;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, cmd_valid, cmd_ready, cmd_signed;
    logic             rsp_valid, rsp_ready, rsp_dbz, rsp_ovf;
    logic [W-1:0]     cmd_a, cmd_b, au_o_i, rsp_data;
    logic [1:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag, rsp_tag;
    logic [2*W+2:0]   au_ip_o;
    logic [CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    au_cmd_driver #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_signed(cmd_signed), .cmd_tag(cmd_tag),
        .au_ip_o(au_ip_o), .au_o_i(au_o_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf),
        .ops_done(ops_done)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        sgn;
        logic [3:0]  tag;
    } cmd_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  tag;
        logic        ovf;
        logic        dbz;
    } rsp_t;

    typedef struct packed {
        cmd_t cmd;
        rsp_t exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    rsp_t        sbQ[$];
    cmd_t        lastCmd;
    cmd_t        curCmd;
    bit          inflight = 0;
    bit          acceptedLast = 0;
    int unsigned popCount = 0;
    cmd_t        idleCmd = '0;

    // Stand-in for the external combinational arithmetic unit; junk on divide by zero.
    function automatic logic [15:0] auUnit(input logic [34:0] ip);
        logic [15:0] a, b;
        logic [1:0]  op;
        logic        s;
        {a, b, op, s} = ip;
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a * b;
            default: begin
                if (b == 16'h0) return 16'hDEAD;
                if (s) begin
                    if (a == 16'h8000 && b == 16'hFFFF) return 16'h8000;
                    return 16'($signed(a) / $signed(b));
                end
                return a / b;
            end
        endcase
    endfunction

    assign au_o_i = auUnit(au_ip_o);

    // Reference result from plain integer arithmetic on the command fields.
    function automatic rsp_t refRsp(input cmd_t c);
        rsp_t   r;
        longint ua, ub, sa, sb, x;
        ua = c.a;
        ub = c.b;
        sa = $signed(c.a);
        sb = $signed(c.b);
        x  = 0;
        r.tag = c.tag;
        r.ovf = 1'b0;
        r.dbz = 1'b0;
        if (c.op == 2'd3 && c.b == 16'h0) begin
            r.dbz  = 1'b1;
            r.data = c.sgn ? 16'h0000 : 16'hFFFF;
            return r;
        end
        case (c.op)
            2'd0: begin
                x = c.sgn ? sa + sb : ua + ub;
                r.ovf = c.sgn ? (x > 32767 || x < -32768) : (x > 65535);
            end
            2'd1: begin
                x = c.sgn ? sa - sb : ua - ub;
                r.ovf = c.sgn ? (x > 32767 || x < -32768) : (x < 0);
            end
            2'd2: x = ua * ub;
            default: begin
                if (c.sgn) begin
                    x = sa / sb;
                    r.ovf = (x > 32767);
                end else begin
                    x = ua / ub;
                end
            end
        endcase
        r.data = x[15:0];
        return r;
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the coming edge.
    task automatic checkOutput();
        int   buffered;
        logic expReady, expValid;
        rsp_t h;
        buffered = sbQ.size() - (inflight ? 1 : 0);
        expReady = !rst && !inflight && (buffered < 2);
        expValid = (buffered > 0);
        compare("cmd_ready", cmd_ready, expReady);
        compare("rsp_valid", rsp_valid, expValid);
        compare("ops_done", ops_done, popCount % 65536);
        if (inflight)
            compare("au_ip_o", au_ip_o, {lastCmd.a, lastCmd.b, lastCmd.op, lastCmd.sgn});
        if (expValid) begin
            h = sbQ[0];
            compare("rsp_data", rsp_data, h.data);
            compare("rsp_tag", rsp_tag, h.tag);
            compare("rsp_ovf", rsp_ovf, h.ovf);
            compare("rsp_dbz", rsp_dbz, h.dbz);
        end
        acceptedLast = 0;
        if (rst) begin
            sbQ.delete();
            inflight = 0;
            popCount = 0;
        end else begin
            if (expValid && rsp_ready) begin
                h = sbQ.pop_front();
                popCount++;
            end
            if (cmd_valid && expReady) begin
                sbQ.push_back(refRsp(curCmd));
                lastCmd      = curCmd;
                inflight     = 1;
                acceptedLast = 1;
            end else begin
                inflight = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input cmd_t c, input logic rr);
        @(negedge clk);
        rst        = r;
        cmd_valid  = v;
        cmd_a      = c.a;
        cmd_b      = c.b;
        cmd_op     = c.op;
        cmd_signed = c.sgn;
        cmd_tag    = c.tag;
        rsp_ready  = rr;
        curCmd     = c;
        #1;
        checkOutput();
    endtask

    function automatic logic [15:0] pickOperand(input bit allowZero);
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return allowZero ? 16'h0000 : 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic cmd_t randCmd();
        cmd_t c;
        c.a   = pickOperand(1'b1);
        c.b   = pickOperand(1'b1);
        c.op  = 2'($urandom_range(0, 3));
        c.sgn = 1'($urandom_range(0, 1));
        c.tag = 4'($urandom);
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[12];
        cmd_t b1, b2, b3, p1, p2, r1;
        cmd_t pend;
        bit   havePend;

        vecs[0]  = '{cmd: '{16'hFFFF, 16'h0002, 2'd0, 1'b0, 4'h3}, exp: '{16'h0001, 4'h3, 1'b1, 1'b0}};
        vecs[1]  = '{cmd: '{16'h8000, 16'h0001, 2'd1, 1'b1, 4'h1}, exp: '{16'h7FFF, 4'h1, 1'b1, 1'b0}};
        vecs[2]  = '{cmd: '{16'h0005, 16'hFFFD, 2'd0, 1'b1, 4'h2}, exp: '{16'h0002, 4'h2, 1'b0, 1'b0}};
        vecs[3]  = '{cmd: '{16'h0064, 16'h0000, 2'd3, 1'b0, 4'h4}, exp: '{16'hFFFF, 4'h4, 1'b0, 1'b1}};
        vecs[4]  = '{cmd: '{16'hFFF9, 16'h0000, 2'd3, 1'b1, 4'h5}, exp: '{16'h0000, 4'h5, 1'b0, 1'b1}};
        vecs[5]  = '{cmd: '{16'h8000, 16'hFFFF, 2'd3, 1'b1, 4'h6}, exp: '{16'h8000, 4'h6, 1'b1, 1'b0}};
        vecs[6]  = '{cmd: '{16'h0003, 16'h0005, 2'd1, 1'b0, 4'h7}, exp: '{16'hFFFE, 4'h7, 1'b1, 1'b0}};
        vecs[7]  = '{cmd: '{16'h0100, 16'h0100, 2'd2, 1'b0, 4'h8}, exp: '{16'h0000, 4'h8, 1'b0, 1'b0}};
        vecs[8]  = '{cmd: '{16'h7FFF, 16'hFFFF, 2'd1, 1'b1, 4'h9}, exp: '{16'h8000, 4'h9, 1'b1, 1'b0}};
        vecs[9]  = '{cmd: '{16'h0064, 16'h0007, 2'd3, 1'b0, 4'hA}, exp: '{16'h000E, 4'hA, 1'b0, 1'b0}};
        vecs[10] = '{cmd: '{16'hFFFF, 16'h0002, 2'd2, 1'b1, 4'hB}, exp: '{16'hFFFE, 4'hB, 1'b0, 1'b0}};
        vecs[11] = '{cmd: '{16'hFFF9, 16'h0002, 2'd3, 1'b1, 4'hF}, exp: '{16'hFFFD, 4'hF, 1'b0, 1'b0}};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_signed = 1'b0; cmd_tag = '0;
        curCmd = '0; lastCmd = '0;
        repeat (2) @(negedge clk);
        compare("reset_cmd_ready", cmd_ready, 1'b0);
        compare("reset_rsp_valid", rsp_valid, 1'b0);
        compare("reset_au_ip_o", au_ip_o, 35'h0);
        compare("reset_ops_done", ops_done, 16'h0);
        compare("reset_rsp_fields", {rsp_data, rsp_tag, rsp_dbz, rsp_ovf}, 22'h0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);

        // Directed vectors: accept, one EXEC cycle, response visible in the following cycle.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, vecs[i].cmd, 1'b0);
            applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
            compare("vec_exec_no_rsp", rsp_valid, 1'b0);
            applyStimulus(1'b0, 1'b0, idleCmd, 1'b1);
            compare("vec_rsp_valid", rsp_valid, 1'b1);
            compare("vec_rsp_data", rsp_data, vecs[i].exp.data);
            compare("vec_rsp_tag", rsp_tag, vecs[i].exp.tag);
            compare("vec_rsp_ovf", rsp_ovf, vecs[i].exp.ovf);
            compare("vec_rsp_dbz", rsp_dbz, vecs[i].exp.dbz);
        end

        // Backpressure: two fill the buffer, the third waits until the first pop.
        applyStimulus(1'b1, 1'b0, idleCmd, 1'b0);
        b1 = '{16'h0001, 16'h0002, 2'd0, 1'b0, 4'h1};
        b2 = '{16'h0010, 16'h0020, 2'd1, 1'b1, 4'h2};
        b3 = '{16'h0003, 16'h0004, 2'd2, 1'b0, 4'h3};
        applyStimulus(1'b0, 1'b1, b1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
        applyStimulus(1'b0, 1'b1, b2, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, b3, 1'b0);
            compare("bp_third_blocked", cmd_ready, 1'b0);
            compare("bp_head_tag", rsp_tag, 4'h1);
        end
        applyStimulus(1'b0, 1'b1, b3, 1'b1);
        compare("bp_blocked_while_full", cmd_ready, 1'b0);
        applyStimulus(1'b0, 1'b1, b3, 1'b1);
        compare("bp_accept_after_pop", cmd_ready, 1'b1);
        compare("bp_second_tag", rsp_tag, 4'h2);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b1);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b1);
        compare("bp_third_data", rsp_data, 16'h000C);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
        compare("bp_ops_done", ops_done, 16'd3);

        // Write and pop on the same edge with one entry buffered.
        p1 = '{16'h1111, 16'h2222, 2'd0, 1'b0, 4'hC};
        p2 = '{16'h0009, 16'h0003, 2'd3, 1'b0, 4'hD};
        applyStimulus(1'b0, 1'b1, p1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
        applyStimulus(1'b0, 1'b1, p2, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b1);
        compare("pp_first_tag", rsp_tag, 4'hC);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b1);
        compare("pp_valid_held", rsp_valid, 1'b1);
        compare("pp_second_data", rsp_data, 16'h0003);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);

        // Reset during EXEC with one entry buffered.
        applyStimulus(1'b0, 1'b1, p1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
        applyStimulus(1'b0, 1'b1, p2, 1'b0);
        applyStimulus(1'b1, 1'b0, idleCmd, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
        compare("rst_mid_rsp_valid", rsp_valid, 1'b0);
        compare("rst_mid_ops_done", ops_done, 16'd0);
        compare("rst_mid_au_ip_o", au_ip_o, 35'h0);
        compare("rst_mid_rsp_data", rsp_data, 16'h0);
        r1 = '{16'h7FFF, 16'h0001, 2'd0, 1'b1, 4'hA};
        applyStimulus(1'b0, 1'b1, r1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b0);
        applyStimulus(1'b0, 1'b0, idleCmd, 1'b1);
        compare("rst_after_valid", rsp_valid, 1'b1);
        compare("rst_after_data", rsp_data, 16'h8000);
        compare("rst_after_ovf", rsp_ovf, 1'b1);
        compare("rst_after_tag", rsp_tag, 4'hA);

        // Random traffic; a refused command is held unchanged until it transfers.
        havePend = 0;
        pend     = '0;
        for (int i = 0; i < 800; i++) begin
            if (!havePend && $urandom_range(0, 2) != 0) begin
                pend     = randCmd();
                havePend = 1;
            end
            applyStimulus(($urandom_range(0, 299) == 0), havePend, pend, ($urandom_range(0, 3) != 0));
            if (acceptedLast) havePend = 0;
        end
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b0, idleCmd, 1'b1);
        compare("drain_empty", sbQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
